inst_fetch: RTL and testbench

Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the instruction decoder. It owns the PC and issues one word fetch at a time over the req/addr_ok/data_ok instruction-SRAM handshake. It buffers the returned word and hands it to ID with a valid/allowin handshake. Branch and jump redirects from ID are applied after the delay-slot instruction, and misaligned PCs are flagged rather than fetched.

---
 rtl/inst_fetch_pkg.sv | 16 +
 rtl/inst_fetch.sv | 111 +++++++++++
 tb/tb_inst_fetch.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package inst_fetch_pkg;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } if_state_e;

  function automatic logic pc_misaligned(input logic [31:0] pc);
    return pc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/inst_fetch.sv
// MIPS IF stage: owns the PC, issues one SRAM word fetch at a time, buffers it for ID
// and applies branch/jump redirects after the delay-slot instruction.
module inst_fetch
  import inst_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  input  logic        id_allowin,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_adel,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  if_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pend_redir_q, pend_redir_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic        if_adel_q, if_adel_d;
  logic [31:0] next_pc;

  // A redirect arriving in the handoff cycle wins over any older pending one.
  assign next_pc = redirect_valid ? redirect_pc : (pend_redir_q ? pend_pc_q : pc_q + 32'd4);

  assign inst_req  = (state_q == S_REQ) && !pc_misaligned(pc_q);
  assign inst_addr = pc_q;
  assign if_valid  = if_valid_q;
  assign if_pc     = if_pc_q;
  assign if_instr  = if_instr_q;
  assign if_adel   = if_adel_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_redir_d = pend_redir_q;
    pend_pc_d    = pend_pc_q;
    if_pc_d      = if_pc_q;
    if_instr_d   = if_instr_q;
    if_adel_d    = if_adel_q;

    if (redirect_valid) begin
      pend_redir_d = 1'b1;
      pend_pc_d    = redirect_pc;
    end

    unique case (state_q)
      S_REQ: begin
        // A misaligned PC never reaches the SRAM; it is delivered as an error slot.
        if (pc_misaligned(pc_q)) begin
          state_d    = S_HOLD;
          if_pc_d    = pc_q;
          if_instr_d = 32'd0;
          if_adel_d  = 1'b1;
        end else if (inst_addr_ok) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (inst_data_ok) begin
          state_d    = S_HOLD;
          if_pc_d    = pc_q;
          if_instr_d = inst_rdata;
          if_adel_d  = 1'b0;
        end
      end
      S_HOLD: begin
        if (id_allowin) begin
          state_d      = S_REQ;
          pc_d         = next_pc;
          pend_redir_d = 1'b0;
        end
      end
      default: state_d = S_REQ;
    endcase

    if_valid_d = (state_d == S_HOLD);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      pend_redir_q <= 1'b0;
      pend_pc_q    <= 32'd0;
      if_valid_q   <= 1'b0;
      if_pc_q      <= RESET_PC;
      if_instr_q   <= 32'd0;
      if_adel_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_redir_q <= pend_redir_d;
      pend_pc_q    <= pend_pc_d;
      if_valid_q   <= if_valid_d;
      if_pc_q      <= if_pc_d;
      if_instr_q   <= if_instr_d;
      if_adel_q    <= if_adel_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed vector table, hand-written corner sequences and a
// randomized SRAM/ID environment checked against a delivery-order reference model.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        id_allowin;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_adel;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int n_cmp  = 0;
  int n_fail = 0;

  inst_fetch dut (
    .clk            (clk),
    .resetn         (resetn),
    .inst_req       (inst_req),
    .inst_addr      (inst_addr),
    .inst_addr_ok   (inst_addr_ok),
    .inst_data_ok   (inst_data_ok),
    .inst_rdata     (inst_rdata),
    .id_allowin     (id_allowin),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .if_adel        (if_adel),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        aok;
    logic        dok;
    logic        allow;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
  } vec_t;

  vec_t vt[18];

  localparam logic [31:0] W0 = 32'h3C08_BFC0;
  localparam logic [31:0] W1 = 32'h2508_0010;
  localparam logic [31:0] W2 = 32'h8D09_0000;
  localparam logic [31:0] W3 = 32'h1120_FFFE;
  localparam logic [31:0] B  = 32'hBFC0_0000;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  function automatic vec_t mk(input logic aok, input logic dok, input logic allow,
                              input logic [31:0] rdata, input logic e_req,
                              input logic [31:0] e_addr, input logic e_valid,
                              input logic [31:0] e_pc, input logic [31:0] e_instr);
    vec_t v;
    v.aok = aok; v.dok = dok; v.allow = allow; v.rdata = rdata;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
    v.e_pc = e_pc; v.e_instr = e_instr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at a negedge; asserts reset between edges and releases on the next negedge.
  task automatic do_reset();
    #2;
    resetn = 1'b0;
    inst_addr_ok = 0; inst_data_ok = 0; inst_rdata = 0;
    id_allowin = 0; redirect_valid = 0; redirect_pc = 0;
    #1;
    chk("rst_valid", {31'd0, if_valid}, 0);
    chk("rst_pc",    if_pc, B);
    chk("rst_instr", if_instr, 0);
    chk("rst_adel",  {31'd0, if_adel}, 0);
    chk("rst_req",   {31'd0, inst_req}, 1);
    chk("rst_addr",  inst_addr, B);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  // From REQ: wait a_lat cycles for addr_ok, then d_lat cycles for data_ok.
  // A redirect pulse is driven in overall cycle index rc (negative = none).
  task automatic do_fetch(input logic [31:0] addr, input int a_lat, input int d_lat,
                          input logic [31:0] word, input int rc, input logic [31:0] rpc);
    int c = 0;
    for (int i = 0; i <= a_lat; i++) begin
      chk("f_req",  {31'd0, inst_req}, 1);
      chk("f_addr", inst_addr, addr);
      inst_addr_ok   = (i == a_lat);
      redirect_valid = (c == rc);
      redirect_pc    = rpc;
      c++;
      @(negedge clk);
    end
    inst_addr_ok = 0;
    for (int i = 1; i <= d_lat; i++) begin
      chk("w_req",   {31'd0, inst_req}, 0);
      chk("w_valid", {31'd0, if_valid}, 0);
      chk("w_addr",  inst_addr, addr);
      inst_data_ok   = (i == d_lat);
      inst_rdata     = word;
      redirect_valid = (c == rc);
      redirect_pc    = rpc;
      c++;
      @(negedge clk);
    end
    inst_data_ok = 0;
    redirect_valid = 0;
  endtask

  task automatic deliver(input logic [31:0] pc, input logic [31:0] instr, input logic adel,
                         input int stall, input logic rv, input logic [31:0] rpc);
    for (int i = 0; i <= stall; i++) begin
      chk("d_valid", {31'd0, if_valid}, 1);
      chk("d_pc",    if_pc, pc);
      chk("d_instr", if_instr, instr);
      chk("d_adel",  {31'd0, if_adel}, {31'd0, adel});
      chk("d_noreq", {31'd0, inst_req}, 0);
      id_allowin     = (i == stall);
      redirect_valid = rv && (i == stall);
      redirect_pc    = rpc;
      @(negedge clk);
    end
    id_allowin = 0;
    redirect_valid = 0;
    chk("d_drop", {31'd0, if_valid}, 0);
  endtask

  // Random-phase state
  logic [31:0] exp_pc, redir_tgt, prev_addr, d_addr, held_pc, held_instr, tgt;
  logic        redir_seen, prev_req, prev_valid, prev_acc, held_adel, exp_adel;
  int          a_wait, d_cnt, idle;

  initial begin
    resetn = 0;
    inst_addr_ok = 0; inst_data_ok = 0; inst_rdata = 0;
    id_allowin = 0; redirect_valid = 0; redirect_pc = 0;
    @(negedge clk);
    do_reset();

    // Zero-wait SRAM: four sequential words, then a 5-cycle ID stall on the fourth.
    vt[0]  = mk(1, 0, 0, 0,  1, B,      0, B,      0);
    vt[1]  = mk(0, 1, 0, W0, 0, B,      0, B,      0);
    vt[2]  = mk(0, 0, 1, 0,  0, B,      1, B,      W0);
    vt[3]  = mk(1, 0, 0, 0,  1, B + 4,  0, B,      W0);
    vt[4]  = mk(0, 1, 0, W1, 0, B + 4,  0, B,      W0);
    vt[5]  = mk(0, 0, 1, 0,  0, B + 4,  1, B + 4,  W1);
    vt[6]  = mk(1, 0, 0, 0,  1, B + 8,  0, B + 4,  W1);
    vt[7]  = mk(0, 1, 0, W2, 0, B + 8,  0, B + 4,  W1);
    vt[8]  = mk(0, 0, 1, 0,  0, B + 8,  1, B + 8,  W2);
    vt[9]  = mk(1, 0, 0, 0,  1, B + 12, 0, B + 8,  W2);
    vt[10] = mk(0, 1, 0, W3, 0, B + 12, 0, B + 8,  W2);
    for (int k = 11; k <= 15; k++) vt[k] = mk(0, 0, 0, 0, 0, B + 12, 1, B + 12, W3);
    vt[16] = mk(0, 0, 1, 0,  0, B + 12, 1, B + 12, W3);
    vt[17] = mk(0, 0, 0, 0,  1, B + 16, 0, B + 12, W3);

    for (int k = 0; k < 18; k++) begin
      chk($sformatf("t%0d_req", k),   {31'd0, inst_req}, {31'd0, vt[k].e_req});
      chk($sformatf("t%0d_addr", k),  inst_addr, vt[k].e_addr);
      chk($sformatf("t%0d_valid", k), {31'd0, if_valid}, {31'd0, vt[k].e_valid});
      chk($sformatf("t%0d_pc", k),    if_pc, vt[k].e_pc);
      chk($sformatf("t%0d_instr", k), if_instr, vt[k].e_instr);
      chk($sformatf("t%0d_adel", k),  {31'd0, if_adel}, 0);
      inst_addr_ok = vt[k].aok;
      inst_data_ok = vt[k].dok;
      inst_rdata   = vt[k].rdata;
      id_allowin   = vt[k].allow;
      @(negedge clk);
    end
    inst_addr_ok = 0; inst_data_ok = 0; id_allowin = 0;

    // Slow SRAM: addr_ok after 3 cycles, data_ok 4 cycles later.
    do_reset();
    do_fetch(B, 3, 4, W1, -1, 0);
    deliver(B, W1, 0, 0, 0, 0);
    do_fetch(B + 4, 0, 1, W2, -1, 0);

    // Redirect while the delay slot at +8 is in WAIT.
    do_reset();
    do_fetch(B, 0, 1, W0, -1, 0);      deliver(B, W0, 0, 0, 0, 0);
    do_fetch(B + 4, 0, 1, W1, -1, 0);  deliver(B + 4, W1, 0, 0, 0, 0);
    do_fetch(B + 8, 0, 2, W2, 1, 32'hBFC0_0100);
    deliver(B + 8, W2, 0, 1, 0, 0);
    do_fetch(32'hBFC0_0100, 0, 1, W3, -1, 0);
    deliver(32'hBFC0_0100, W3, 0, 0, 0, 0);

    // Redirect coinciding with the handoff cycle, then sequential from the target.
    do_reset();
    do_fetch(B, 0, 1, W0, -1, 0);
    deliver(B, W0, 0, 0, 1, 32'h8000_0000);
    do_fetch(32'h8000_0000, 1, 2, W1, -1, 0);
    deliver(32'h8000_0000, W1, 0, 0, 0, 0);
    do_fetch(32'h8000_0004, 0, 1, W2, -1, 0);

    // Misaligned redirect target: error slot, never fetched.
    do_reset();
    do_fetch(B, 0, 1, W0, -1, 0);      deliver(B, W0, 0, 0, 0, 0);
    do_fetch(B + 4, 0, 1, W1, 1, 32'hBFC0_0102);
    deliver(B + 4, W1, 0, 0, 0, 0);
    chk("mis_noreq", {31'd0, inst_req}, 0);
    @(negedge clk);
    deliver(32'hBFC0_0102, 32'd0, 1, 1, 0, 0);

    // Reset while waiting for data.
    do_reset();
    do_fetch(B, 0, 1, W0, -1, 0);      deliver(B, W0, 0, 0, 0, 0);
    chk("rw_req", {31'd0, inst_req}, 1);
    inst_addr_ok = 1;
    @(negedge clk);
    inst_addr_ok = 0;
    chk("rw_wait", {31'd0, inst_req}, 0);
    do_reset();
    do_fetch(B, 0, 1, W3, -1, 0);
    deliver(B, W3, 0, 0, 0, 0);

    // Randomized SRAM latency, ID back-pressure and redirects against an in-order model.
    do_reset();
    exp_pc = B; redir_seen = 0; redir_tgt = 0;
    prev_req = 0; prev_addr = 0; prev_valid = 0; prev_acc = 0;
    held_pc = 0; held_instr = 0; held_adel = 0;
    a_wait = 0; d_cnt = 0; d_addr = 0; idle = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (inst_req) begin
        chk("r_req_aligned", {30'd0, inst_addr[1:0]}, 0);
        if (prev_req) chk("r_addr_stable", inst_addr, prev_addr);
        else chk("r_single_outstanding", d_cnt, 0);
      end
      if (if_valid) begin
        idle = 0;
        if (prev_valid && !prev_acc) begin
          chk("r_hold_pc",    if_pc, held_pc);
          chk("r_hold_instr", if_instr, held_instr);
          chk("r_hold_adel",  {31'd0, if_adel}, {31'd0, held_adel});
        end else begin
          exp_adel = (exp_pc[1:0] != 2'b00);
          chk("r_pc",    if_pc, exp_pc);
          chk("r_adel",  {31'd0, if_adel}, {31'd0, exp_adel});
          chk("r_instr", if_instr, exp_adel ? 32'd0 : mem(exp_pc));
        end
        held_pc = if_pc; held_instr = if_instr; held_adel = if_adel;
      end else begin
        idle++;
        if (idle > 40) begin
          chk("r_progress_timeout", idle, 0);
          break;
        end
      end

      inst_data_ok = 0;
      if (d_cnt > 0) begin
        d_cnt--;
        if (d_cnt == 0) begin
          inst_data_ok = 1;
          inst_rdata   = mem(d_addr);
        end
      end
      inst_addr_ok = 0;
      if (inst_req) begin
        if (!prev_req) a_wait = $urandom_range(0, 3);
        if (a_wait == 0) begin
          inst_addr_ok = 1;
          d_cnt  = $urandom_range(1, 4);
          d_addr = inst_addr;
        end else begin
          a_wait--;
        end
      end
      prev_req  = inst_req && !inst_addr_ok;
      prev_addr = inst_addr;

      id_allowin     = ($urandom % 3) != 0;
      redirect_valid = ($urandom % 10) == 0;
      tgt = B + ($urandom_range(0, 255) << 2);
      if (($urandom % 4) == 0) tgt = tgt | 32'd2;
      redirect_pc = tgt;
      if (redirect_valid) begin
        redir_seen = 1;
        redir_tgt  = tgt;
      end
      prev_acc = if_valid && id_allowin;
      if (prev_acc) begin
        exp_pc     = redir_seen ? redir_tgt : exp_pc + 32'd4;
        redir_seen = 0;
      end
      prev_valid = if_valid;
      @(negedge clk);
    end
    inst_addr_ok = 0; inst_data_ok = 0; id_allowin = 0; redirect_valid = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
